// File: rtl/envelope_adsr.sv
// Per-channel ADSR amplitude envelope applied to a 16-bit unsigned sample stream.
// Optional ENVELOPE_EXP_EN: decay/release steps of max(1, level>>4) for an exponential-like tail.
module envelope_adsr #(
  parameter int DATA_W = 16,
  parameter int LVL_W  = 8,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freq,
  input  logic              gate_on,
  input  logic              gate_off,
  input  logic [RATE_W-1:0] attack,
  input  logic [RATE_W-1:0] decay,
  input  logic [LVL_W-1:0]  sustain,
  // "release" is a reserved word in SystemVerilog, hence the longer name
  input  logic [RATE_W-1:0] release_rate,
  input  logic [DATA_W-1:0] soundIn,
  input  logic              start,
  output logic [DATA_W-1:0] soundOut,
  output logic              startO,
  output logic [LVL_W-1:0]  level,
  output logic [2:0]        state,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam int                PW       = DATA_W + LVL_W;
  localparam logic [LVL_W-1:0]  LVL_MAX  = {LVL_W{1'b1}};
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

  env_state_t        state_r;
  logic [LVL_W-1:0]  level_r;
  logic [RATE_W-1:0] presc_r;
  logic [RATE_W-1:0] att_r;
  logic [RATE_W-1:0] dec_r;
  logic [RATE_W-1:0] rel_r;
  logic [LVL_W-1:0]  sus_r;
  logic              busy_r;

  logic [RATE_W-1:0] rate_s;
  logic [LVL_W-1:0]  up_s;
  logic [LVL_W-1:0]  down_s;
  logic              stepping_s;
  logic              release_ok_s;

  logic [PW-1:0]     prod_s;
  logic [DATA_W-1:0] mul_r;
  logic              zero_r;
  logic              v1_r;
  logic [DATA_W-1:0] sound_r;
  logic              start_o_r;
  logic              unused_s;

  // Level after one decay/release step, never wrapping below zero.
  function automatic logic [LVL_W-1:0] fall_level(input logic [LVL_W-1:0] lvl);
`ifdef ENVELOPE_EXP_EN
    logic [LVL_W-1:0] amt;
    amt = lvl >> 3'd4;
    if (amt == '0) begin
      amt = LVL_ONE;
    end else begin
      amt = amt;
    end
    return (lvl > amt) ? (lvl - amt) : '0;
`else
    return (lvl == '0) ? '0 : (lvl - LVL_ONE);
`endif
  endfunction

  // Active rate selection and the candidate next levels for a step.
  always_comb begin
    rate_s = '0;
    case (state_r)
      ST_ATTACK:  rate_s = att_r;
      ST_DECAY:   rate_s = dec_r;
      ST_RELEASE: rate_s = rel_r;
      default:    rate_s = '0;
    endcase
    up_s         = (level_r == LVL_MAX) ? LVL_MAX : (level_r + LVL_ONE);
    down_s       = fall_level(level_r);
    stepping_s   = (state_r == ST_ATTACK) || (state_r == ST_DECAY) || (state_r == ST_RELEASE);
    release_ok_s = (state_r == ST_ATTACK) || (state_r == ST_DECAY) || (state_r == ST_SUSTAIN);
  end

  // Envelope FSM: gate events take priority over the freq-driven step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      level_r <= '0;
      presc_r <= '0;
      att_r   <= '0;
      dec_r   <= '0;
      rel_r   <= '0;
      sus_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      if (gate_off) begin
        rel_r <= release_rate;
      end
      if (gate_on) begin
        att_r   <= attack;
        dec_r   <= decay;
        sus_r   <= sustain;
        state_r <= ST_ATTACK;
        presc_r <= '0;
        busy_r  <= 1'b1;
      end else if (gate_off && release_ok_s) begin
        state_r <= ST_RELEASE;
        presc_r <= '0;
      end else if (freq && stepping_s) begin
        if (presc_r != rate_s) begin
          presc_r <= presc_r + RATE_ONE;
        end else begin
          presc_r <= '0;
          case (state_r)
            ST_ATTACK: begin
              level_r <= up_s;
              if (up_s == LVL_MAX) begin
                state_r <= (sus_r == LVL_MAX) ? ST_SUSTAIN : ST_DECAY;
              end
            end
            ST_DECAY: begin
              if (down_s <= sus_r) begin
                level_r <= sus_r;
                state_r <= ST_SUSTAIN;
              end else begin
                level_r <= down_s;
              end
            end
            ST_RELEASE: begin
              level_r <= down_s;
              if (down_s == '0) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end
            default: begin
              level_r <= level_r;
            end
          endcase
        end
      end
    end
  end

  // soundIn*(level+1) written as soundIn*level + soundIn so it fits PW bits.
  always_comb begin
    prod_s   = (PW'(soundIn) * PW'(level_r)) + PW'(soundIn);
    unused_s = ^prod_s[LVL_W-1:0];
  end

  // Two-stage scaling pipeline: multiply register, then output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_r     <= '0;
      zero_r    <= 1'b0;
      v1_r      <= 1'b0;
      sound_r   <= '0;
      start_o_r <= 1'b0;
    end else begin
      v1_r <= start;
      if (start) begin
        mul_r  <= prod_s[PW-1:LVL_W];
        zero_r <= (level_r == '0);
      end
      start_o_r <= v1_r;
      if (v1_r) begin
        sound_r <= zero_r ? '0 : mul_r;
      end
    end
  end

  assign soundOut = sound_r;
  assign startO   = start_o_r;
  assign level    = level_r;
  assign state    = state_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_envelope_adsr.sv
// Scoreboard bench for envelope_adsr: directed ADSR, scaling, retrigger and edge cases.
module tb_envelope_adsr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freq = 1'b0;
  logic        gate_on = 1'b0;
  logic        gate_off = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  attack = 8'd0;
  logic [7:0]  decay = 8'd0;
  logic [7:0]  sustain = 8'd0;
  logic [7:0]  release_rate = 8'd0;
  logic [15:0] soundIn = 16'd0;
  logic [15:0] soundOut;
  logic        startO;
  logic [7:0]  level;
  logic [2:0]  state;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  envelope_adsr dut (
    .clk(clk), .rst(rst), .freq(freq), .gate_on(gate_on), .gate_off(gate_off),
    .attack(attack), .decay(decay), .sustain(sustain), .release_rate(release_rate),
    .soundIn(soundIn), .start(start), .soundOut(soundOut), .startO(startO),
    .level(level), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    freq = 1'b1;
    clocks(n);
    freq = 1'b0;
  endtask

  task automatic pulse_on();
    gate_on = 1'b1;
    clocks(1);
    gate_on = 1'b0;
  endtask

  task automatic pulse_off();
    gate_off = 1'b1;
    clocks(1);
    gate_off = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] e);
    exp_t item;
    item.data = e;
    item.due  = cyc + 2;
    sb_q.push_back(item);
    soundIn = d;
    start = 1'b1;
    clocks(1);
    start = 1'b0;
  endtask

  task automatic chk_env(input string name, input logic [2:0] st, input logic [7:0] lv);
    chk({name, "_state"}, 32'(state), 32'(st));
    chk({name, "_level"}, 32'(level), 32'(lv));
  endtask

  // Monitor: every output strobe must match the oldest expectation and its due cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (startO) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL startO_unexpected: got strobe at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("soundOut", 32'(soundOut), 32'(e.data));
        chk("startO_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] prev;
    logic       wrapped;
    logic [7:0] first_rel;

    // Reset held while inputs toggle
    soundIn = 16'hFFFF;
    start = 1'b1; gate_on = 1'b1; freq = 1'b1;
    clocks(3);
    start = 1'b0; gate_on = 1'b0; freq = 1'b0;
    chk("rst_soundOut", 32'(soundOut), 32'h0);
    chk("rst_startO", 32'(startO), 32'h0);
    chk_env("rst", 3'd0, 8'd0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    clocks(2);
    chk_env("post_rst", 3'd0, 8'd0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Full ADSR cycle; rate inputs scrambled after latching
    attack = 8'd0; decay = 8'd1; sustain = 8'd128; release_rate = 8'd3;
    pulse_on();
    attack = 8'd50; decay = 8'd50; sustain = 8'd10;
    chk_env("gate_on", 3'd1, 8'd0);
    chk("gate_on_busy", 32'(busy), 32'h1);
    ticks(254);
    chk_env("attack_254", 3'd1, 8'd254);
    ticks(1);
    chk_env("attack_top", 3'd2, 8'd255);

    // Scaling at full scale, back-to-back strobes
    send(16'hABCD, 16'hABCD);
    send(16'h0001, 16'h0001);
    clocks(4);
    chk("soundOut_hold", 32'(soundOut), 32'h0001);

    ticks(253);
    chk_env("decay_253", 3'd2, 8'd129);
    ticks(1);
    chk_env("decay_end", 3'd3, 8'd128);
    ticks(10);
    chk_env("sustain_hold", 3'd3, 8'd128);
    send(16'h1234, 16'h092C);
    clocks(2);

    release_rate = 8'd3;
    pulse_off();
    release_rate = 8'd0;
    chk_env("gate_off", 3'd4, 8'd128);
    ticks(4);
    chk_env("release_4", 3'd4, 8'd127);
    send(16'hFFFF, 16'h7FFF);
    clocks(2);
    ticks(507);
    chk_env("release_511", 3'd4, 8'd1);
    ticks(1);
    chk_env("release_end", 3'd0, 8'd0);
    chk("release_end_busy", 32'(busy), 32'h0);
    send(16'hFFFF, 16'h0000);
    clocks(2);

    // gate_off while idle is ignored
    pulse_off();
    chk_env("idle_gate_off", 3'd0, 8'd0);
    chk("idle_gate_off_busy", 32'(busy), 32'h0);

    // Retrigger from RELEASE at 60, with a coincident freq tick discarded
    attack = 8'd0; decay = 8'd0; sustain = 8'd60;
    pulse_on();
    freq = 1'b1;
    for (int i = 0; i < 1000 && state != 3'd3; i++) clocks(1);
    freq = 1'b0;
    chk_env("to_sustain60", 3'd3, 8'd60);
    release_rate = 8'd0;
    pulse_off();
    chk_env("rel60", 3'd4, 8'd60);
    gate_on = 1'b1; freq = 1'b1;
    clocks(1);
    gate_on = 1'b0; freq = 1'b0;
    chk_env("retrigger", 3'd1, 8'd60);
    ticks(1);
    chk_env("retrigger_step", 3'd1, 8'd61);

    // Reset mid-note drops the in-flight strobe
    soundIn = 16'h5555;
    start = 1'b1;
    clocks(1);
    start = 1'b0;
    rst = 1'b0;
    #1;
    chk_env("mid_rst", 3'd0, 8'd0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    clocks(3);
    chk("mid_rst_startO", 32'(startO), 32'h0);
    rst = 1'b1;
    clocks(1);

    // Simultaneous gate_on and gate_off from IDLE
    gate_on = 1'b1; gate_off = 1'b1;
    clocks(1);
    gate_on = 1'b0; gate_off = 1'b0;
    chk_env("both_gates", 3'd1, 8'd0);
    chk("both_gates_busy", 32'(busy), 32'h1);

    // sustain=255 skips DECAY
    attack = 8'd0; decay = 8'd0; sustain = 8'd255;
    pulse_on();
    ticks(255);
    chk_env("sus255", 3'd3, 8'd255);

    // Release from 255 at rate 0: first step size and no wrap
`ifdef ENVELOPE_EXP_EN
    first_rel = 8'd240;
`else
    first_rel = 8'd254;
`endif
    release_rate = 8'd0;
    pulse_off();
    ticks(1);
    chk_env("rel255_first", 3'd4, first_rel);
    prev = level;
    wrapped = 1'b0;
    freq = 1'b1;
    for (int i = 0; i < 600 && state != 3'd0; i++) begin
      clocks(1);
      if (level > prev) wrapped = 1'b1;
      prev = level;
    end
    freq = 1'b0;
    chk("rel255_nowrap", 32'(wrapped), 32'h0);
    chk_env("rel255_end", 3'd0, 8'd0);

    clocks(4);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
